mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 159 +++++++++++++++
 tb/tb_mem_access_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the micro-op stage and a ready/valid data memory.
// Issues one access at a time, stalls upstream while waiting, and aborts after MAX_WAIT cycles.
module mem_access_unit #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic        reg_we,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_addr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        stall,
  output logic        err_misalign,
  output logic        err_illegal,
  output logic        err_timeout
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [4:0]  r_rd, w_rd_nxt;
  logic        r_req, w_req_nxt;
  logic        r_we, w_we_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic        r_wb_en, w_wb_en_nxt;
  logic [4:0]  r_wb_addr, w_wb_addr_nxt;
  logic [31:0] r_wb_data, w_wb_data_nxt;
  logic        r_err_mis, w_err_mis_nxt;
  logic        r_err_ill, w_err_ill_nxt;
  logic        r_err_to, w_err_to_nxt;

  assign w_cnt_inc = r_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rd_nxt      = r_rd;
    w_req_nxt     = r_req;
    w_we_nxt      = r_we;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_wb_en_nxt   = 1'b0;
    w_wb_addr_nxt = r_wb_addr;
    w_wb_data_nxt = r_wb_data;
    w_err_mis_nxt = 1'b0;
    w_err_ill_nxt = 1'b0;
    w_err_to_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_re && mem_we) begin
          w_err_ill_nxt = 1'b1;
        end else if (mem_re || mem_we) begin
          if (alu_result[1:0] != 2'b00) begin
            w_err_mis_nxt = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = '0;
            w_req_nxt   = 1'b1;
            w_we_nxt    = mem_we;
            w_addr_nxt  = alu_result;
            if (mem_we) w_wdata_nxt = rs2_data;
            else        w_rd_nxt    = rd_addr;
          end
        end else if (reg_we && (rd_addr != 5'd0)) begin
          w_wb_en_nxt   = 1'b1;
          w_wb_addr_nxt = rd_addr;
          w_wb_data_nxt = alu_result;
        end
      end
      S_WAIT: begin
        if (dmem_ready) begin
          w_state_nxt = S_IDLE;
          w_req_nxt   = 1'b0;
          if (!r_we && (r_rd != 5'd0)) begin
            w_wb_en_nxt   = 1'b1;
            w_wb_addr_nxt = r_rd;
            w_wb_data_nxt = dmem_rdata;
          end
        end else begin
          // Compare the post-increment value so the abort lands on the MAX_WAIT-th WAIT cycle.
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == 8'(MAX_WAIT)) begin
            w_state_nxt  = S_IDLE;
            w_req_nxt    = 1'b0;
            w_err_to_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_rd      <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wb_en   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_err_mis <= 1'b0;
      r_err_ill <= 1'b0;
      r_err_to  <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_rd      <= w_rd_nxt;
      r_req     <= w_req_nxt;
      r_we      <= w_we_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_wb_en   <= w_wb_en_nxt;
      r_wb_addr <= w_wb_addr_nxt;
      r_wb_data <= w_wb_data_nxt;
      r_err_mis <= w_err_mis_nxt;
      r_err_ill <= w_err_ill_nxt;
      r_err_to  <= w_err_to_nxt;
    end
  end

  assign stall        = (r_state == S_WAIT);
  assign dmem_req     = r_req;
  assign dmem_we      = r_we;
  assign dmem_addr    = r_addr;
  assign dmem_wdata   = r_wdata;
  assign wb_en        = r_wb_en;
  assign wb_addr      = r_wb_addr;
  assign wb_data      = r_wb_data;
  assign err_misalign = r_err_mis;
  assign err_illegal  = r_err_ill;
  assign err_timeout  = r_err_to;

endmodule

// File: tb/tb_mem_access_unit.sv
// Transaction-level bench for mem_access_unit: each operation's outcome is derived from
// its kind, alignment and memory latency, with inputs randomised while the unit is stalled.
module tb_mem_access_unit;

  localparam int unsigned MAXW = 4;

  logic        clk;
  logic        rst_n;
  logic        mem_re, mem_we, reg_we;
  logic [31:0] alu_result, rs2_data;
  logic [4:0]  rd_addr;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall, err_misalign, err_illegal, err_timeout;

  int n_checks = 0;
  int n_err    = 0;

  mem_access_unit #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_re(mem_re), .mem_we(mem_we), .reg_we(reg_we),
    .alu_result(alu_result), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(stall), .err_misalign(err_misalign), .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_re = 1'b0; mem_we = 1'b0; reg_we = 1'b0;
    alu_result = '0; rs2_data = '0; rd_addr = '0;
  endtask

  task automatic garbage_inputs();
    mem_re     = 1'($urandom());
    mem_we     = 1'($urandom());
    reg_we     = 1'($urandom());
    alu_result = $urandom();
    rs2_data   = $urandom();
    rd_addr    = 5'($urandom());
  endtask

  // Load (we=0) or store (we=1); memory answers in WAIT cycle k, k > MAXW means never.
  task automatic t_mem(input logic we, input logic [31:0] addr, input logic [4:0] rd,
                       input logic [31:0] data, input int unsigned k);
    int unsigned n_wait;
    logic        exp_wb;
    mem_re = ~we; mem_we = we; reg_we = 1'($urandom());
    alu_result = addr; rd_addr = rd;
    rs2_data = we ? data : $urandom();
    dmem_ready = 1'b0;
    @(negedge clk);
    if (addr[1:0] != 2'b00) begin
      idle_inputs();
      chk("misalign_pulse", 32'(err_misalign), 32'd1);
      chk("misalign_other_err", {30'd0, err_illegal, err_timeout}, 32'd0);
      chk("misalign_no_req", {29'd0, dmem_req, stall, wb_en}, 32'd0);
      return;
    end
    n_wait = (k <= MAXW) ? k : MAXW;
    for (int unsigned i = 1; i <= n_wait; i++) begin
      chk("wait_stall_req", {30'd0, stall, dmem_req}, 32'd3);
      chk("wait_we", 32'(dmem_we), 32'(we));
      chk("wait_addr", dmem_addr, addr);
      if (we) chk("wait_wdata", dmem_wdata, data);
      chk("wait_quiet", {28'd0, wb_en, err_misalign, err_illegal, err_timeout}, 32'd0);
      garbage_inputs();
      dmem_ready = (i == k);
      dmem_rdata = (i == k) ? data : $urandom();
      @(negedge clk);
    end
    dmem_ready = 1'b0;
    dmem_rdata = $urandom();
    idle_inputs();
    exp_wb = !we && (k <= MAXW) && (rd != 5'd0);
    chk("done_idle", {30'd0, stall, dmem_req}, 32'd0);
    chk("done_timeout", 32'(err_timeout), 32'(k > MAXW));
    chk("done_wb_en", 32'(wb_en), 32'(exp_wb));
    if (exp_wb) begin
      chk("done_wb_addr", 32'(wb_addr), 32'(rd));
      chk("done_wb_data", wb_data, data);
    end
    chk("done_other_err", {30'd0, err_misalign, err_illegal}, 32'd0);
  endtask

  task automatic t_alu(input logic [4:0] rd, input logic [31:0] val);
    mem_re = 1'b0; mem_we = 1'b0; reg_we = 1'b1;
    rd_addr = rd; alu_result = val; rs2_data = $urandom();
    @(negedge clk);
    idle_inputs();
    chk("alu_wb_en", 32'(wb_en), 32'(rd != 5'd0));
    if (rd != 5'd0) begin
      chk("alu_wb_addr", 32'(wb_addr), 32'(rd));
      chk("alu_wb_data", wb_data, val);
    end
    chk("alu_quiet", {27'd0, err_misalign, err_illegal, err_timeout, stall, dmem_req}, 32'd0);
  endtask

  task automatic t_illegal();
    mem_re = 1'b1; mem_we = 1'b1; reg_we = 1'($urandom());
    alu_result = $urandom(); rs2_data = $urandom(); rd_addr = 5'($urandom_range(1, 31));
    @(negedge clk);
    idle_inputs();
    chk("illegal_pulse", 32'(err_illegal), 32'd1);
    chk("illegal_quiet", {28'd0, err_misalign, err_timeout, wb_en, dmem_req}, 32'd0);
    chk("illegal_no_stall", 32'(stall), 32'd0);
  endtask

  task automatic t_nop();
    idle_inputs();
    alu_result = $urandom(); rd_addr = 5'($urandom()); rs2_data = $urandom();
    @(negedge clk);
    idle_inputs();
    chk("nop_quiet", {26'd0, wb_en, err_misalign, err_illegal, err_timeout, stall, dmem_req}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    idle_inputs();
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {26'd0, dmem_req, dmem_we, wb_en, stall, err_misalign, err_illegal}, 32'd0);
    chk("rst_timeout", 32'(err_timeout), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_wb_addr", 32'(wb_addr), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    rst_n = 1'b1;

    t_mem(1'b0, 32'h100, 5'd5, 32'hDEADBEEF, 3);
    t_mem(1'b1, 32'h204, 5'd9, 32'h12345678, 1);
    t_alu(5'd7, 32'h55);
    t_alu(5'd0, 32'h99);
    t_nop();
    t_mem(1'b0, 32'h102, 5'd3, 32'hCAFEF00D, 1);
    t_illegal();
    t_nop();
    t_mem(1'b0, 32'h300, 5'd4, 32'hA5A5A5A5, MAXW + 1);
    t_mem(1'b0, 32'h300, 5'd4, 32'h5A5A5A5A, MAXW);
    t_mem(1'b1, 32'h308, 5'd4, 32'h0BADF00D, MAXW + 1);
    t_mem(1'b0, 32'h30C, 5'd0, 32'h11111111, 2);

    // Reset in the second WAIT cycle of a load.
    mem_re = 1'b1; alu_result = 32'h400; rd_addr = 5'd6;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    chk("rstwait_stall_before", {30'd0, stall, dmem_req}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rstwait_drop", {30'd0, stall, dmem_req}, 32'd0);
    chk("rstwait_addr", dmem_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dmem_ready = 1'b1;
    dmem_rdata = $urandom();
    repeat (3) begin
      @(negedge clk);
      chk("rstwait_quiet", {27'd0, wb_en, err_misalign, err_illegal, err_timeout, stall}, 32'd0);
    end
    dmem_ready = 1'b0;

    for (int n = 0; n < 200; n++) begin
      a = $urandom();
      case ($urandom_range(0, 9))
        0, 1, 2: t_mem(1'b0, {a[31:2], 2'b00}, 5'($urandom()), $urandom(), $urandom_range(1, MAXW + 2));
        3, 4:    t_mem(1'b1, {a[31:2], 2'b00}, 5'($urandom()), $urandom(), $urandom_range(1, MAXW + 2));
        5:       t_mem(1'($urandom()), {a[31:2], 2'($urandom_range(1, 3))}, 5'($urandom()), $urandom(), 1);
        6, 7:    t_alu(5'($urandom()), $urandom());
        8:       t_illegal();
        default: t_nop();
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
